// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: fixed-latency memory freeze,
// load-use bubble insertion, taken-branch flushes and saturating debug counters.
module hazard_stall_ctrl #(
    parameter int MEM_LATENCY = 6,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_src1,
    input  logic [4:0]       id_src2,
    input  logic             id_uses_src2,
    input  logic [4:0]       exe_dest,
    input  logic             exe_mem_read,
    input  logic             branch_taken,
    input  logic             mem_req,
    output logic             pc_freeze,
    output logic             ifid_freeze,
    output logic             pipe_freeze,
    output logic             ifid_flush,
    output logic             idexe_flush,
    output logic             mem_done,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // The first cycle of an access is spent in RUN, the last at cnt==0 in WAIT.
    localparam logic [3:0] LOAD_VAL = (MEM_LATENCY > 1) ? 4'(MEM_LATENCY - 2) : 4'd0;

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       mem_freeze;
    logic       load_use;
    logic [2:0] event_inc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_RUN;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign load_use = exe_mem_read && (exe_dest != 5'd0) &&
                      ((id_src1 == exe_dest) || (id_uses_src2 && (id_src2 == exe_dest)));

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        mem_freeze  = 1'b0;
        mem_done    = 1'b0;
        pc_freeze   = 1'b0;
        ifid_freeze = 1'b0;
        pipe_freeze = 1'b0;
        ifid_flush  = 1'b0;
        idexe_flush = 1'b0;
        event_inc   = 3'b000;

        case (state_reg)
            ST_RUN: begin
                if (mem_req) begin
                    if (MEM_LATENCY > 1) begin
                        mem_freeze = 1'b1;
                        state_next = ST_WAIT;
                        cnt_next   = LOAD_VAL;
                    end else begin
                        mem_done = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_reg != 4'd0) begin
                    mem_freeze = 1'b1;
                    cnt_next   = cnt_reg - 4'd1;
                end else begin
                    // mem_req is still high here for the departing access; not a new request.
                    mem_done   = 1'b1;
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
                cnt_next   = 4'd0;
            end
        endcase

        if (mem_freeze) begin
            pc_freeze    = 1'b1;
            ifid_freeze  = 1'b1;
            pipe_freeze  = 1'b1;
            event_inc[0] = 1'b1;
        end else if (branch_taken) begin
            // Both younger instructions are wrong-path, so a load-use match is moot.
            ifid_flush   = 1'b1;
            idexe_flush  = 1'b1;
            event_inc[2] = 1'b1;
        end else if (load_use) begin
            pc_freeze    = 1'b1;
            ifid_freeze  = 1'b1;
            idexe_flush  = 1'b1;
            event_inc[1] = 1'b1;
        end
    end

    // Index 0: stall cycles, 1: load-use bubbles, 2: branch flushes.
    logic [CNT_W-1:0] event_cnt_reg [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_event_cnt
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    event_cnt_reg[gi] <= '0;
                end else if (event_inc[gi] && (event_cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    event_cnt_reg[gi] <= event_cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign stall_cycles = event_cnt_reg[0];
    assign bubble_count = event_cnt_reg[1];
    assign flush_count  = event_cnt_reg[2];

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; narrow counters make saturation reachable quickly.
module tb_hazard_stall_ctrl;

    localparam int MEM_LATENCY = 6;
    localparam int CNT_W       = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic [4:0]       id_src1, id_src2, exe_dest;
    logic             id_uses_src2, exe_mem_read, branch_taken, mem_req;
    logic             pc_freeze, ifid_freeze, pipe_freeze, ifid_flush, idexe_flush, mem_done;
    logic [CNT_W-1:0] stall_cycles, bubble_count, flush_count;

    int checks   = 0;
    int failures = 0;

    hazard_stall_ctrl #(.MEM_LATENCY(MEM_LATENCY), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_uses_src2 (id_uses_src2),
        .exe_dest     (exe_dest),
        .exe_mem_read (exe_mem_read),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .pc_freeze    (pc_freeze),
        .ifid_freeze  (ifid_freeze),
        .pipe_freeze  (pipe_freeze),
        .ifid_flush   (ifid_flush),
        .idexe_flush  (idexe_flush),
        .mem_done     (mem_done),
        .stall_cycles (stall_cycles),
        .bubble_count (bubble_count),
        .flush_count  (flush_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        id_src1 = 5'd0; id_src2 = 5'd0; id_uses_src2 = 1'b0; exe_dest = 5'd0;
        exe_mem_read = 1'b0; branch_taken = 1'b0; mem_req = 1'b0;
    endtask

    // Control outputs packed as {pc,ifid,pipe,ifid_flush,idexe_flush,mem_done}.
    function automatic logic [5:0] ctrl();
        return {pc_freeze, ifid_freeze, pipe_freeze, ifid_flush, idexe_flush, mem_done};
    endfunction

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        #2;
        checks++;
        if (ctrl() !== 6'b000000) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl(), 6'b000000);
        end
        checks++;
        if ({stall_cycles, bubble_count, flush_count} !== '0) begin
            failures++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", stall_cycles, bubble_count, flush_count);
        end
        $display("test_reset: ctrl=%b counters=%0d/%0d/%0d", ctrl(), stall_cycles, bubble_count, flush_count);
        tick();
    endtask

    task automatic test_mem_access();
        logic [5:0] exp;
        mem_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            #2;
            exp = (c == 6 || c == 12) ? 6'b000001 : 6'b111000;
            checks++;
            if (ctrl() !== exp) begin
                failures++; $display("FAIL mem_cycle%0d got=%b exp=%b", c, ctrl(), exp);
            end
            if (c == 7) begin
                checks++;
                if (stall_cycles !== 4'd5) begin
                    failures++; $display("FAIL mem_stall_after_first got=%0d exp=5", stall_cycles);
                end
            end
            $display("test_mem_access: cycle=%0d ctrl=%b stall=%0d", c, ctrl(), stall_cycles);
            tick();
        end
        mem_req = 1'b0;
        #2;
        checks++;
        if (ctrl() !== 6'b000000 || stall_cycles !== 4'd10) begin
            failures++; $display("FAIL mem_after got=%b/%0d exp=000000/10", ctrl(), stall_cycles);
        end
        tick();
    endtask

    task automatic test_load_use();
        // rt match with id_uses_src2 -> bubble
        id_src1 = 5'd3; id_src2 = 5'd5; id_uses_src2 = 1'b1; exe_dest = 5'd5; exe_mem_read = 1'b1;
        #2;
        checks++;
        if (ctrl() !== 6'b110010) begin
            failures++; $display("FAIL lu_src2 got=%b exp=110010", ctrl());
        end
        $display("test_load_use: src2 match ctrl=%b", ctrl());
        tick();
        clear_inputs();
        #2;
        checks++;
        if (ctrl() !== 6'b000000 || bubble_count !== 4'd1) begin
            failures++; $display("FAIL lu_clear got=%b/%0d exp=000000/1", ctrl(), bubble_count);
        end
        tick();
        // exe_dest == 0 never hazards
        exe_mem_read = 1'b1; exe_dest = 5'd0; id_src1 = 5'd0; id_src2 = 5'd0; id_uses_src2 = 1'b1;
        #2;
        checks++;
        if (ctrl() !== 6'b000000) begin
            failures++; $display("FAIL lu_dest0 got=%b exp=000000", ctrl());
        end
        $display("test_load_use: dest0 ctrl=%b", ctrl());
        tick();
        // rt match but rt not a source -> no bubble
        exe_dest = 5'd9; id_src1 = 5'd1; id_src2 = 5'd9; id_uses_src2 = 1'b0;
        #2;
        checks++;
        if (ctrl() !== 6'b000000) begin
            failures++; $display("FAIL lu_src2_unused got=%b exp=000000", ctrl());
        end
        tick();
        // rs match
        exe_dest = 5'd7; id_src1 = 5'd7; id_src2 = 5'd2;
        #2;
        checks++;
        if (ctrl() !== 6'b110010) begin
            failures++; $display("FAIL lu_src1 got=%b exp=110010", ctrl());
        end
        tick();
        clear_inputs();
        #2;
        checks++;
        if (bubble_count !== 4'd2) begin
            failures++; $display("FAIL lu_count got=%0d exp=2", bubble_count);
        end
        $display("test_load_use: bubble_count=%0d", bubble_count);
        tick();
    endtask

    task automatic test_branch_priority();
        exe_mem_read = 1'b1; exe_dest = 5'd4; id_src1 = 5'd4; branch_taken = 1'b1;
        #2;
        checks++;
        if (ctrl() !== 6'b000110) begin
            failures++; $display("FAIL br_prio got=%b exp=000110", ctrl());
        end
        tick();
        clear_inputs();
        #2;
        checks++;
        if (flush_count !== 4'd1 || bubble_count !== 4'd2) begin
            failures++; $display("FAIL br_counts got=%0d/%0d exp=1/2", flush_count, bubble_count);
        end
        $display("test_branch_priority: flush=%0d bubble=%0d", flush_count, bubble_count);
        tick();
    endtask

    task automatic test_branch_during_wait();
        mem_req = 1'b1;
        tick();
        tick();
        branch_taken = 1'b1;
        #2;
        checks++;
        if (ctrl() !== 6'b111000) begin
            failures++; $display("FAIL br_wait got=%b exp=111000", ctrl());
        end
        tick();
        branch_taken = 1'b0;
        tick();
        tick();
        branch_taken = 1'b1;
        #2;
        checks++;
        if (ctrl() !== 6'b000111) begin
            failures++; $display("FAIL br_done got=%b exp=000111", ctrl());
        end
        tick();
        clear_inputs();
        #2;
        checks++;
        if (flush_count !== 4'd2 || stall_cycles !== 4'd15) begin
            failures++; $display("FAIL br_wait_counts got=%0d/%0d exp=2/15", flush_count, stall_cycles);
        end
        $display("test_branch_during_wait: flush=%0d stall=%0d", flush_count, stall_cycles);
        tick();
    endtask

    task automatic test_saturation();
        // One more access: stall counter already all-ones.
        mem_req = 1'b1;
        repeat (6) tick();
        clear_inputs();
        // 15 bubbles and 15 branch flushes push both counters past all-ones.
        exe_mem_read = 1'b1; exe_dest = 5'd8; id_src1 = 5'd8;
        repeat (15) tick();
        clear_inputs();
        branch_taken = 1'b1;
        repeat (15) tick();
        clear_inputs();
        #2;
        checks++;
        if (stall_cycles !== 4'hF) begin
            failures++; $display("FAIL sat_stall got=%0d exp=15", stall_cycles);
        end
        checks++;
        if (bubble_count !== 4'hF) begin
            failures++; $display("FAIL sat_bubble got=%0d exp=15", bubble_count);
        end
        checks++;
        if (flush_count !== 4'hF) begin
            failures++; $display("FAIL sat_flush got=%0d exp=15", flush_count);
        end
        $display("test_saturation: counters=%0d/%0d/%0d", stall_cycles, bubble_count, flush_count);
        tick();
    endtask

    task automatic test_reset_in_wait();
        mem_req = 1'b1;
        tick();
        tick();
        #2;
        mem_req = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (ctrl() !== 6'b000000 || {stall_cycles, bubble_count, flush_count} !== '0) begin
            failures++; $display("FAIL rst_wait_async got=%b/%0d/%0d/%0d exp=000000/0/0/0", ctrl(), stall_cycles, bubble_count, flush_count);
        end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #2;
            checks++;
            if (ctrl() !== 6'b000000) begin
                failures++; $display("FAIL rst_wait_cycle%0d got=%b exp=000000", c, ctrl());
            end
            tick();
        end
        $display("test_reset_in_wait: ctrl=%b stall=%0d", ctrl(), stall_cycles);
    endtask

    initial begin
        test_reset();
        test_mem_access();
        test_load_use();
        test_branch_priority();
        test_branch_during_wait();
        test_saturation();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Central stall/flush sequencer for the five-stage pipeline. Each cycle it decides whether the PC, IF/ID, ID/EXE and downstream pipeline registers advance, hold or are flushed. Inputs are a fixed-latency data-memory access, load-use hazards and taken branches. It drives the `flush` inputs of the IF/ID and ID/EXE registers and the freeze inputs of the PC and all pipeline registers. It also keeps saturating stall/flush event counters for debug.

## Interface
- `MEM_LATENCY`, default 6: total cycles of one data-memory access, legal range 1..15.
- `CNT_W`, default 16: width of the event counters.

- `clock`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-high.
- `id_src1`, input, 5: rs of the instruction in ID.
- `id_src2`, input, 5: rt of the instruction in ID.
- `id_uses_src2`, input, 1: the ID instruction reads `id_src2` as a source.
- `exe_dest`, input, 5: destination of the instruction in EXE.
- `exe_mem_read`, input, 1: the EXE instruction is a load.
- `branch_taken`, input, 1: branch resolved taken in EXE this cycle.
- `mem_req`, input, 1: the MEM-stage instruction performs a load or store.
- `pc_freeze`, output, 1: hold the PC.
- `ifid_freeze`, output, 1: hold IF/ID.
- `pipe_freeze`, output, 1: hold ID/EXE, EXE/MEM and MEM/WB.
- `ifid_flush`, output, 1: clear IF/ID at the next edge.
- `idexe_flush`, output, 1: clear ID/EXE at the next edge, inserting a bubble.
- `mem_done`, output, 1: last cycle of a memory access.
- `stall_cycles`, output, `CNT_W`: count of cycles with `pipe_freeze`=1.
- `bubble_count`, output, `CNT_W`: count of load-use bubbles inserted.
- `flush_count`, output, `CNT_W`: count of taken-branch flushes.

## Operation
- State machine with two states, RUN and WAIT, plus a 4-bit down-counter `cnt`.
- RUN, `mem_req`=1 and `MEM_LATENCY`>1:
  - `pipe_freeze`=`pc_freeze`=`ifid_freeze`=1.
  - Next state WAIT, `cnt` loaded with `MEM_LATENCY`-2.
- RUN, `mem_req`=1 and `MEM_LATENCY`=1: no freeze, `mem_done`=1, stay in RUN.
- WAIT, `cnt`≠0: all three freezes asserted, `cnt` decrements.
- WAIT, `cnt`=0:
  - Freezes released by the memory path, `mem_done`=1.
  - Next state RUN.
  - `mem_req` is ignored in this cycle; it is still high because the instruction is leaving MEM.
- A memory access therefore occupies exactly `MEM_LATENCY` cycles, with the freeze asserted for the first `MEM_LATENCY`-1 of them.
- Hazard logic is evaluated only in cycles where the memory freeze is 0. Priority order:
  1. `branch_taken`=1: `ifid_flush`=`idexe_flush`=1 and no freeze. Both younger instructions are wrong-path, so any load-use match is ignored. `flush_count` increments.
  2. Load-use: `exe_mem_read`=1, `exe_dest`≠0, and either `id_src1`==`exe_dest` or (`id_uses_src2` and `id_src2`==`exe_dest`). Response: `pc_freeze`=`ifid_freeze`=1, `idexe_flush`=1, `pipe_freeze`=0. `bubble_count` increments.
  3. Otherwise all control outputs are 0.
- While the memory freeze is asserted: `ifid_flush`=`idexe_flush`=0, the branch and hazard inputs are ignored, and `stall_cycles` increments.
- Control outputs are combinational from state, `cnt` and inputs. Counters are registered.
- Each counter saturates at all-ones and never wraps.

## Timing
- Reset (asynchronous): state RUN, `cnt`=0, all counters 0. Combinational outputs follow on the next input evaluation. A reset during WAIT abandons the access, and no `mem_done` is issued.
- Hazard and flush responses have zero-cycle latency: they are asserted in the same cycle as the triggering inputs and act at the next rising edge.
- Load-use costs exactly one bubble. On the following cycle the load is in MEM and `exe_mem_read` refers to the bubble (0), so the hazard clears without internal state.
- A load in MEM that also has a dependent instruction in ID: the memory freeze dominates for `MEM_LATENCY`-1 cycles. The hazard is then re-evaluated in the `mem_done` cycle from that cycle's inputs.
- Back-to-back accesses: the cycle after `mem_done` is in RUN, so a new `mem_req` starts a fresh `MEM_LATENCY` window with no gap cycle.

## Test plan
- Reset held, then released with all inputs 0 → every control output 0, all counters 0, state RUN.
- `mem_req`=1 held through a 6-cycle access (`MEM_LATENCY`=6) → `pipe_freeze`=1 for 5 cycles, `mem_done`=1 in cycle 6, `stall_cycles`=5. A new `mem_req` in cycle 7 → freeze re-asserts immediately.
- `exe_mem_read`=1, `exe_dest`=5, `id_src2`=5, `id_uses_src2`=1 for one cycle → `pc_freeze`=`ifid_freeze`=`idexe_flush`=1 and `pipe_freeze`=0 for 1 cycle, `bubble_count`=1. Repeat with `exe_dest`=0 → no bubble.
- `branch_taken`=1 together with a matching load-use → `ifid_flush`=`idexe_flush`=1, no freeze, `flush_count`=1, `bubble_count` unchanged.
- `branch_taken`=1 in the 3rd cycle of a memory wait → no flush, freeze continues. Asserted in the `mem_done` cycle → flush issued.
- Assert reset in the 2nd WAIT cycle, then release → outputs 0 in RUN, no `mem_done`. Preload the counters near all-ones and check that they saturate.
